// File: rtl/adc_sclk_burst_gen.sv
// SPI serial-clock generator for the ADC front end: programmable half-period,
// burst or continuous framing, and edge strobes so all shifting runs on clk_clk.
module adc_sclk_burst_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6,
  parameter bit CPOL  = 1'b0
) (
  input  logic             clk_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             continuous,
  input  logic             start,
  input  logic             stop,
  output logic             SCLK,
  output logic             PE_SCLK,
  output logic             NE_SCLK,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] h_lat;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] edge_cnt;
  logic             cont_lat;
  logic             stop_pend;
  logic             sclk_q;
  logic             done_q;

  logic toggle;
  logic trailing;
  logic stop_req;
  logic last_edge;
  logic early_stop;

  // With H=0 the leading edge of an idle-level cycle is already strobed, so a
  // stop there lets that SCLK cycle complete instead of exiting immediately.
  always_comb begin
    toggle     = (state == RUN) && (div == h_lat);
    trailing   = toggle && (sclk_q != CPOL);
    stop_req   = stop || stop_pend;
    last_edge  = trailing &&
                 (stop_req || (!cont_lat && (CNT_W'(edge_cnt + CNT_W'(1)) == n_lat)));
    early_stop = (state == RUN) && stop_req && (sclk_q == CPOL) &&
                 (div == '0) && (h_lat != '0);
  end

  assign SCLK       = sclk_q;
  assign PE_SCLK    = toggle && !sclk_q;
  assign NE_SCLK    = toggle && sclk_q;
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign edge_count = edge_cnt;

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      h_lat     <= '0;
      n_lat     <= '0;
      cont_lat  <= 1'b0;
      stop_pend <= 1'b0;
      edge_cnt  <= '0;
      sclk_q    <= CPOL;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk_q <= CPOL;
          if (start) begin
            h_lat     <= half_period;
            n_lat     <= burst_len;
            cont_lat  <= continuous;
            div       <= '0;
            edge_cnt  <= '0;
            stop_pend <= 1'b0;
            state     <= (!continuous && (burst_len == '0)) ? TAIL : RUN;
          end
        end
        RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (early_stop) begin
            div   <= '0;
            state <= TAIL;
          end else if (toggle) begin
            sclk_q <= ~sclk_q;
            div    <= '0;
            if (trailing) edge_cnt <= edge_cnt + CNT_W'(1);
            if (last_edge) state <= TAIL;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        TAIL: begin
          // Chip-select hold: SCLK parked at idle level for H+1 cycles.
          if (div == h_lat) begin
            div    <= '0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sclk_burst_gen.sv
// Self-checking bench: CPOL=0 and CPOL=1 instances share stimulus and are
// compared cycle by cycle against a frame-level arithmetic model.
module tb_adc_sclk_burst_gen;

  logic       clk_clk = 1'b0;
  logic       reset, start, stop, continuous;
  logic [7:0] half_period;
  logic [5:0] burst_len;

  logic       sclk0, pe0, ne0, busy0, done0;
  logic [5:0] ec0;
  logic       sclk1, pe1, ne1, busy1, done1;
  logic [5:0] ec1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int h; int n; bit cont; int s; bit sws;
    int expDone; int expEc;
  } vec_t;

  vec_t tbl[11];

  always #5 clk_clk = ~clk_clk;

  adc_sclk_burst_gen #(.DIV_W(8), .CNT_W(6), .CPOL(1'b0)) dut0 (
    .clk_clk(clk_clk), .reset(reset), .half_period(half_period),
    .burst_len(burst_len), .continuous(continuous), .start(start), .stop(stop),
    .SCLK(sclk0), .PE_SCLK(pe0), .NE_SCLK(ne0), .busy(busy0), .done(done0),
    .edge_count(ec0));

  adc_sclk_burst_gen #(.DIV_W(8), .CNT_W(6), .CPOL(1'b1)) dut1 (
    .clk_clk(clk_clk), .reset(reset), .half_period(half_period),
    .burst_len(burst_len), .continuous(continuous), .start(start), .stop(stop),
    .SCLK(sclk1), .PE_SCLK(pe1), .NE_SCLK(ne1), .busy(busy1), .done(done1),
    .edge_count(ec1));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Number of RUN cycles in a frame, from the framing rules alone.
  function automatic int runLength(int h, int n, bit cont, int s);
    int hp = h + 1;
    int per = 2 * hp;
    int len = cont ? 32'h7fffffff : 2 * n * hp;
    int sl;
    if (s >= 0) begin
      if (((s / hp) % 2) == 0 && (s % hp) == 0 && h != 0) sl = s + 1;
      else sl = (s / per + 1) * per;
      if (sl < len) len = sl;
    end
    return len;
  endfunction

  // Expected outputs of both instances in frame cycle c (c=0 is the first cycle after start).
  function automatic logic [31:0] expVec(int c, int h, int runlen);
    int hp = h + 1;
    int fin = (runlen / (2 * hp)) % 64;
    bit lvl = 1'b0, pe = 1'b0, ne = 1'b0, bsy = 1'b1, dn = 1'b0;
    int ec = fin;
    if (c < runlen) begin
      lvl = ((c / hp) % 2) == 1;
      pe  = ((c % hp) == h) && !lvl;
      ne  = ((c % hp) == h) && lvl;
      ec  = (c / (2 * hp)) % 64;
    end else if (c >= runlen + hp) begin
      bsy = 1'b0;
      dn  = 1'b1;
    end
    return {10'b0, lvl, pe, ne, bsy, dn, 6'(ec), !lvl, ne, pe, bsy, dn, 6'(ec)};
  endfunction

  function automatic logic [31:0] actVec();
    return {10'b0, sclk0, pe0, ne0, busy0, done0, ec0, sclk1, pe1, ne1, busy1, done1, ec1};
  endfunction

  task automatic applyStimulus(input int h, input int n, input bit cont, input int s,
                               input bit sws, input bit busyStart,
                               output int doneOff, output int finalEc);
    int runlen = runLength(h, n, cont, s);
    int last   = runlen + h + 1;
    int bsAt   = busyStart ? int'($urandom_range(0, last - 1)) : -1;
    int fin    = (runlen / (2 * (h + 1))) % 64;
    doneOff = -1;
    finalEc = -1;
    half_period = 8'(h);
    burst_len   = 6'(n);
    continuous  = cont;
    start = 1'b1;
    stop  = sws;
    @(negedge clk_clk);
    checkOutput("idle_before_start",
                {22'b0, sclk0, pe0, ne0, busy0, done0, sclk1, pe1, ne1, busy1, done1},
                32'b0000010000);
    @(posedge clk_clk); #1;
    for (int c = 0; c <= last; c++) begin
      start       = (c == bsAt);
      stop        = (c == s);
      half_period = 8'($urandom);
      burst_len   = 6'($urandom);
      continuous  = 1'($urandom);
      @(negedge clk_clk);
      checkOutput("frame_cycle", actVec(), expVec(c, h, runlen));
      if (done0 && doneOff < 0) begin
        doneOff = c + 1;
        finalEc = int'(ec0);
      end
      @(posedge clk_clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk_clk);
    checkOutput("hold_after_done", {18'b0, busy0, done0, ec0, busy1, done1, ec1},
                {18'b0, 2'b00, 6'(fin), 2'b00, 6'(fin)});
    @(posedge clk_clk); #1;
  endtask

  initial begin
    int dOff, fEc, r, h, n, s;
    bit cont;

    tbl[0]  = '{11, 16, 1'b0, -1,  1'b0, 397, 16};
    tbl[1]  = '{0,  3,  1'b0, -1,  1'b1, 8,   3};
    tbl[2]  = '{3,  0,  1'b1, 5,   1'b0, 13,  1};
    tbl[3]  = '{2,  2,  1'b0, -1,  1'b0, 16,  2};
    tbl[4]  = '{5,  0,  1'b0, -1,  1'b0, 7,   0};
    tbl[5]  = '{0,  0,  1'b1, 2,   1'b0, 6,   2};
    tbl[6]  = '{4,  0,  1'b1, 10,  1'b0, 17,  1};
    tbl[7]  = '{1,  2,  1'b0, 7,   1'b0, 11,  2};
    tbl[8]  = '{0,  0,  1'b1, 140, 1'b0, 144, 7};
    tbl[9]  = '{2,  5,  1'b0, 8,   1'b0, 16,  2};
    tbl[10] = '{3,  4,  1'b1, 0,   1'b1, 6,   0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    half_period = '0; burst_len = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    @(negedge clk_clk);
    checkOutput("reset_state", actVec(), {10'b0, 5'b00000, 6'd0, 5'b10000, 6'd0});
    @(posedge clk_clk); #1;
    reset = 1'b0;
    @(posedge clk_clk); #1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].h, tbl[i].n, tbl[i].cont, tbl[i].s, tbl[i].sws, 1'b1, dOff, fEc);
      checkOutput($sformatf("done_time_%0d", i), 32'(dOff), 32'(tbl[i].expDone));
      checkOutput($sformatf("final_count_%0d", i), 32'(fEc), 32'(tbl[i].expEc));
    end

    // Reset in the middle of a burst: outputs return to reset values, no done.
    half_period = 8'd2; burst_len = 6'd5; continuous = 1'b0; start = 1'b1;
    @(posedge clk_clk); #1;
    start = 1'b0;
    r = int'($urandom_range(3, 20));
    repeat (r) begin
      @(posedge clk_clk); #1;
    end
    reset = 1'b1;
    @(posedge clk_clk); #1;
    reset = 1'b0;
    @(negedge clk_clk);
    checkOutput("reset_mid_frame", actVec(), {10'b0, 5'b00000, 6'd0, 5'b10000, 6'd0});
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_clk); #1;
      @(negedge clk_clk);
      checkOutput("idle_after_reset", {28'b0, busy0, done0, busy1, done1}, 32'b0);
    end
    @(posedge clk_clk); #1;

    for (int i = 0; i < 25; i++) begin
      h    = int'($urandom_range(0, 6));
      n    = int'($urandom_range(0, 8));
      cont = 1'($urandom_range(0, 1));
      if (cont) s = int'($urandom_range(0, 40));
      else if ($urandom_range(0, 1) == 0) s = -1;
      else s = int'($urandom_range(0, 2 * n * (h + 1) + h));
      applyStimulus(h, n, cont, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dOff, fEc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
